push_seq: RTL and testbench

Sequencer for PUSH0–PUSH32 execution in the EVM core. On a start pulse it charges gas and fetches the 0–32 immediate bytes from code memory one byte at a time, reading bytes past the end of code as zero. It assembles them into a right-aligned 256-bit word and hands that word to the stack over a valid/ready handshake. It sits between the decode stage, the byte-wide code memory port and the stack write port. It reports the next PC and the remaining gas.

---
 rtl/evm_pkg.sv | 22 ++
 rtl/push_acc.sv | 26 ++
 rtl/push_seq.sv | 158 +++++++++++++++
 tb/tb_push_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evm_pkg.sv
// Shared EVM core definitions: opcode bounds, gas tiers and the PUSH sequencer state set.
package evm_pkg;

  localparam logic [7:0] OP_PUSH0  = 8'h5F;
  localparam logic [7:0] OP_PUSH32 = 8'h7F;

  localparam int G_BASE    = 2;
  localparam int G_VERYLOW = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PUSH  = 3'd3,
    ST_FIN   = 3'd4
  } push_state_e;

  function automatic logic is_push(input logic [7:0] op);
    return (op >= OP_PUSH0) && (op <= OP_PUSH32);
  endfunction

endpackage

// File: rtl/push_acc.sv
// 256-bit byte-shift accumulator: each accepted byte enters at the LSB end so the
// immediate ends up right-aligned once all bytes have been shifted in.
module push_acc (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         shift_en_i,
  input  logic [7:0]   din_i,
  output logic [255:0] acc_o
);

  logic [255:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (shift_en_i) begin
      acc_q <= {acc_q[247:0], din_i};
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/push_seq.sv
// PUSH0..PUSH32 sequencer: charges gas, fetches immediates byte by byte, pushes the word.
// Optional macro PUSH_SEQ_GAS_CHECK_EN enables the out-of-gas error.
module push_seq
  import evm_pkg::*;
#(
  parameter int CODE_AW = 16,
  parameter int GAS_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         opcode,
  input  logic [CODE_AW-1:0] pc,
  input  logic [CODE_AW:0]   code_len,
  input  logic [GAS_W-1:0]   gas_in,
  output logic               busy,
  output logic               code_req,
  output logic [CODE_AW-1:0] code_addr,
  input  logic [7:0]         code_rdata,
  input  logic               code_rvalid,
  output logic               stk_valid,
  output logic [255:0]       stk_data,
  input  logic               stk_ready,
  output logic               done,
  output logic               err,
  output logic [CODE_AW-1:0] pc_nxt,
  output logic [GAS_W-1:0]   gas_out
);

  push_state_e        state_q, state_d;
  logic [5:0]         i_q, i_d;
  logic [CODE_AW-1:0] pc_nxt_q, pc_nxt_d;
  logic [GAS_W-1:0]   gas_q, gas_d;
  logic [CODE_AW-1:0] pc_q;
  logic [CODE_AW:0]   clen_q;
  logic [5:0]         n_q;

  logic [5:0]         n_start;
  logic [GAS_W-1:0]   cost;
  logic               bad_op;
  logic               oog;
  logic [CODE_AW:0]   addr;
  logic               in_range;
  logic               load;
  logic               acc_clr;
  logic               acc_shift;
  logic [7:0]         acc_din;
  logic [5:0]         i_inc;
  logic [255:0]       acc;

  // Low six opcode bits minus 0x1F equal opcode - 0x5F across the whole PUSH range.
  assign n_start = opcode[5:0] - 6'h1F;
  assign cost    = (opcode == OP_PUSH0) ? GAS_W'(G_BASE) : GAS_W'(G_VERYLOW);
  assign bad_op  = !is_push(opcode);
`ifdef PUSH_SEQ_GAS_CHECK_EN
  assign oog     = (gas_in < cost);
`else
  assign oog     = 1'b0;
`endif

  // Extra address bit catches wrap past the top of code space.
  assign addr     = {1'b0, pc_q} + (CODE_AW+1)'(i_q) + (CODE_AW+1)'(1);
  assign in_range = !addr[CODE_AW] && (addr < clen_q);
  assign i_inc    = i_q + 6'd1;

  assign acc_shift = ((state_q == ST_FETCH) && !in_range) ||
                     ((state_q == ST_WAIT) && code_rvalid);
  assign acc_din   = (state_q == ST_WAIT) ? code_rdata : 8'h00;

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    pc_nxt_d = pc_nxt_q;
    gas_d    = gas_q;
    load     = 1'b0;
    acc_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          acc_clr = 1'b1;
          i_d     = '0;
          if (bad_op || oog) begin
            state_d  = ST_FIN;
            pc_nxt_d = pc;
            gas_d    = gas_in;
          end else begin
            pc_nxt_d = pc + CODE_AW'(n_start) + CODE_AW'(1);
            gas_d    = gas_in - cost;
            state_d  = (opcode == OP_PUSH0) ? ST_PUSH : ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (in_range) begin
          state_d = ST_WAIT;
        end else begin
          i_d     = i_inc;
          state_d = (i_inc == n_q) ? ST_PUSH : ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (code_rvalid) begin
          i_d     = i_inc;
          state_d = (i_inc == n_q) ? ST_PUSH : ST_FETCH;
        end
      end
      ST_PUSH: begin
        if (stk_ready) state_d = ST_IDLE;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      pc_nxt_q <= '0;
      gas_q    <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      pc_nxt_q <= pc_nxt_d;
      gas_q    <= gas_d;
    end
  end

  // Instruction operands are only consulted after a start has loaded them.
  always_ff @(posedge clk) begin
    if (load) begin
      pc_q   <= pc;
      clen_q <= code_len;
      n_q    <= n_start;
    end
  end

  push_acc u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (acc_clr),
    .shift_en_i (acc_shift),
    .din_i      (acc_din),
    .acc_o      (acc)
  );

  assign busy      = (state_q != ST_IDLE);
  assign code_req  = (state_q == ST_FETCH) && in_range;
  assign code_addr = code_req ? addr[CODE_AW-1:0] : '0;
  assign stk_valid = (state_q == ST_PUSH);
  assign stk_data  = acc;
  assign done      = (state_q == ST_FIN) || ((state_q == ST_PUSH) && stk_ready);
  assign err       = (state_q == ST_FIN);
  assign pc_nxt    = pc_nxt_q;
  assign gas_out   = gas_q;

endmodule

// File: tb/tb_push_seq.sv
// Self-checking bench for push_seq: directed cases plus randomized pushes against a
// specification-level model (byte list -> right-aligned word).
module tb_push_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   opcode;
  logic [15:0]  pc;
  logic [16:0]  code_len;
  logic [31:0]  gas_in;
  logic         busy;
  logic         code_req;
  logic [15:0]  code_addr;
  logic [7:0]   code_rdata;
  logic         code_rvalid;
  logic         stk_valid;
  logic [255:0] stk_data;
  logic         stk_ready;
  logic         done;
  logic         err;
  logic [15:0]  pc_nxt;
  logic [31:0]  gas_out;

  logic         rv_mem, rv_man;
  logic [7:0]   mem_data, man_data;
  logic [7:0]   mem [0:65535];
  logic         mem_en;
  int           mem_lat_max;
  int           req_cnt;

  int n_cmp;
  int n_bad;

  logic [255:0] r_data;
  logic         r_err;
  logic [15:0]  r_pc;
  logic [31:0]  r_gas;
  int           r_reads;
  int           r_cyc;

  assign code_rvalid = rv_mem | rv_man;
  assign code_rdata  = rv_man ? man_data : mem_data;

  push_seq #(.CODE_AW(16), .GAS_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .opcode      (opcode),
    .pc          (pc),
    .code_len    (code_len),
    .gas_in      (gas_in),
    .busy        (busy),
    .code_req    (code_req),
    .code_addr   (code_addr),
    .code_rdata  (code_rdata),
    .code_rvalid (code_rvalid),
    .stk_valid   (stk_valid),
    .stk_data    (stk_data),
    .stk_ready   (stk_ready),
    .done        (done),
    .err         (err),
    .pc_nxt      (pc_nxt),
    .gas_out     (gas_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Code memory: answers each request after 1 + random(0..mem_lat_max) cycles.
  initial begin
    logic [15:0] a;
    int lat;
    rv_mem   = 1'b0;
    mem_data = 8'h00;
    req_cnt  = 0;
    forever begin
      @(negedge clk);
      if (code_req) begin
        req_cnt++;
        if (mem_en) begin
          a   = code_addr;
          lat = $urandom_range(0, mem_lat_max);
          @(posedge clk);
          repeat (lat) @(posedge clk);
          #1;
          mem_data = mem[a];
          rv_mem   = 1'b1;
          @(posedge clk);
          #1 rv_mem = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: gather n immediate bytes (zero past end of code), concatenate them.
  function automatic void model(input logic [7:0] op, input logic [15:0] a_pc,
                                input logic [16:0] a_len, input logic [31:0] a_gas,
                                output logic [255:0] w, output logic e,
                                output logic [15:0] pn, output logic [31:0] go,
                                output int reads);
    int cost, n, a;
    logic bad;
    cost  = (op == 8'h5F) ? 2 : 3;
    bad   = (op < 8'h5F) || (op > 8'h7F);
`ifdef PUSH_SEQ_GAS_CHECK_EN
    if (a_gas < 32'(cost)) bad = 1'b1;
`endif
    w     = '0;
    reads = 0;
    if (bad) begin
      e  = 1'b1;
      pn = a_pc;
      go = a_gas;
    end else begin
      e = 1'b0;
      n = int'(op) - 8'h5F;
      for (int j = 0; j < n; j++) begin
        a = int'(a_pc) + 1 + j;
        if (a < int'(a_len) && a < 65536) begin
          w = (w << 8) | 256'(mem[a]);
          reads++;
        end else begin
          w = w << 8;
        end
      end
      pn = 16'(int'(a_pc) + 1 + n);
      go = a_gas - 32'(cost);
    end
  endfunction

  task automatic run_chk(input string tag, input logic [7:0] op, input logic [15:0] a_pc,
                         input logic [16:0] a_len, input logic [31:0] a_gas, input int exp_cyc);
    logic [255:0] ew;
    logic ee, ok, saw;
    logic [15:0] ep;
    logic [31:0] eg;
    int er, r0;
    model(op, a_pc, a_len, a_gas, ew, ee, ep, eg, er);
    @(posedge clk);
    #1;
    r0 = req_cnt;
    start = 1'b1; opcode = op; pc = a_pc; code_len = a_len; gas_in = a_gas;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b0; saw = 1'b0; r_cyc = 0;
    for (int k = 1; k <= 300 && !ok; k++) begin
      @(negedge clk);
      if (stk_valid) saw = 1'b1;
      if (done) begin
        ok = 1'b1; r_cyc = k;
        r_data = stk_data; r_err = err; r_pc = pc_nxt; r_gas = gas_out;
      end
    end
    r_reads = req_cnt - r0;
    chk({tag, "_done"}, ok, 1'b1);
    chk({tag, "_err"}, r_err, ee);
    chk({tag, "_pcnxt"}, r_pc, ep);
    chk({tag, "_gas"}, r_gas, eg);
    chk({tag, "_reads"}, r_reads, er);
    chk({tag, "_pushed"}, saw, !ee);
    if (!ee) chk({tag, "_data"}, r_data, ew);
    if (exp_cyc > 0) chk({tag, "_cyc"}, r_cyc, exp_cyc);
    @(negedge clk);
    chk({tag, "_busy_fall"}, busy, 1'b0);
  endtask

  initial begin
    logic [255:0] w32, held, ew;
    logic ee, ok;
    logic [15:0] ep, p16;
    logic [31:0] eg, g32;
    logic [7:0] op8;
    int er, pcv, lenv;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; opcode = 8'h00; pc = '0; code_len = '0; gas_in = '0;
    stk_ready = 1'b1; rv_man = 1'b0; man_data = 8'h00; mem_en = 1'b1; mem_lat_max = 0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    mem[16'h0011] = 8'hAB;
    for (int a = 1; a <= 9; a++) mem[a] = 8'(a);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", code_req, 1'b0);
    chk("rst_valid", stk_valid, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_data", stk_data, 256'd0);
    chk("rst_pcnxt", pc_nxt, 16'd0);
    #1 rst_n = 1'b1;

    run_chk("push1", 8'h60, 16'h0010, 17'h00020, 32'd10, 3);
    chk("push1_value", r_data, 256'hAB);
    chk("push1_gas_const", r_gas, 32'd7);
    run_chk("push0", 8'h5F, 16'h0123, 17'h00200, 32'd2, 1);
    chk("push0_pc_const", r_pc, 16'h0124);
    run_chk("push32", 8'h7F, 16'h0000, 17'd10, 32'd100, -1);
    w32 = 256'h010203040506070809;
    w32 = w32 << 184;
    chk("push32_value", r_data, w32);
    chk("push32_reads", r_reads, 9);
    run_chk("push2_oog", 8'h61, 16'h0200, 17'h00300, 32'd2, -1);
`ifdef PUSH_SEQ_GAS_CHECK_EN
    chk("oog_err_const", r_err, 1'b1);
    chk("oog_cyc", r_cyc, 1);
`else
    chk("oog_gas_wrap", r_gas, 32'hFFFF_FFFF);
`endif
    run_chk("bad_5e", 8'h5E, 16'h0050, 17'h00100, 32'd50, 1);
    run_chk("bad_80", 8'h80, 16'h0050, 17'h00100, 32'd50, 1);
    run_chk("pc_wrap", 8'h63, 16'hFFFE, 17'h10000, 32'd9, -1);

    // Back-pressure: word held while stack is not ready, start ignored while busy.
    mem_lat_max = 1;
    model(8'h61, 16'h0100, 17'h00200, 32'd50, ew, ee, ep, eg, er);
    stk_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; opcode = 8'h61; pc = 16'h0100; code_len = 17'h00200; gas_in = 32'd50;
    @(posedge clk);
    #1 start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (stk_valid) ok = 1'b1;
    end
    chk("stall_valid_seen", ok, 1'b1);
    held = stk_data;
    chk("stall_data", held, ew);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 start = (k == 2); opcode = 8'h5F; pc = 16'h0777;
      @(negedge clk);
      chk("stall_hold_valid", stk_valid, 1'b1);
      chk("stall_hold_data", stk_data, held);
      chk("stall_no_done", done, 1'b0);
    end
    @(posedge clk);
    #1 start = 1'b0; stk_ready = 1'b1;
    @(negedge clk);
    chk("stall_done", done, 1'b1);
    chk("stall_err", err, 1'b0);
    chk("stall_pcnxt", pc_nxt, ep);
    @(negedge clk);
    chk("stall_busy_fall", busy, 1'b0);
    @(negedge clk);
    chk("stall_start_ignored", busy, 1'b0);

    // Reset during WAIT, then a stale read response.
    mem_en = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; opcode = 8'h60; pc = 16'h0040; code_len = 17'h00100; gas_in = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("mid_req", code_req, 1'b1);
    @(negedge clk);
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_req", code_req, 1'b0);
    chk("mid_rst_pcnxt", pc_nxt, 16'd0);
    chk("mid_rst_gas", gas_out, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 rv_man = 1'b1; man_data = 8'h55;
    @(posedge clk);
    #1 rv_man = 1'b0;
    @(negedge clk);
    chk("late_busy", busy, 1'b0);
    chk("late_valid", stk_valid, 1'b0);
    chk("late_data", stk_data, 256'd0);
    mem_en = 1'b1;
    mem_lat_max = 0;
    run_chk("after_rst", 8'h60, 16'h0010, 17'h00020, 32'd10, 3);

    // Randomized sequences.
    mem_lat_max = 2;
    for (int t = 0; t < 40; t++) begin
      op8 = 8'($urandom_range(8'h5C, 8'h82));
      case ($urandom_range(0, 2))
        0:       pcv = $urandom_range(0, 64);
        1:       pcv = $urandom_range(16'hFFD0, 16'hFFFF);
        default: pcv = $urandom_range(0, 16'hFFFF);
      endcase
      if ($urandom_range(0, 1) == 1) lenv = pcv + $urandom_range(0, 40);
      else                           lenv = $urandom_range(0, 32'h10000);
      if (lenv > 32'h10000) lenv = 32'h10000;
      p16 = 16'(pcv);
      g32 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 5)) : $urandom;
      run_chk("rand", op8, p16, 17'(lenv), g32, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
